// File: rtl/apb_slave_pkg.sv
// Shared types and width helpers for the APB completer memory (apb_slave_mem).
package apb_slave_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int BYTE_W = 8;

  function automatic int addr_lsb_f(input int data_width);
    return $clog2(data_width / BYTE_W);
  endfunction

  function automatic int strb_width_f(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Word array behind the APB completer: asynchronous clear, byte-lane writes,
// combinational read port. Out-of-range indices read as zero and never write.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IDX_W-1:0]        widx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_W-1:0]        ridx,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int STRB_W = strb_width_f(DATA_WIDTH);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  widx_ok_s;
  logic                  ridx_ok_s;

  assign widx_ok_s = ({1'b0, widx} < DEPTH_L);
  assign ridx_ok_s = ({1'b0, ridx} < DEPTH_L);

  // Next array contents: merge the enabled byte lanes into the addressed word.
  always_comb begin
    mem_d = mem_q;
    if (we && widx_ok_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        mem_d[widx[MEM_AW-1:0]][b*BYTE_W +: BYTE_W] =
          wstrb[b] ? wdata[b*BYTE_W +: BYTE_W] : mem_q[widx[MEM_AW-1:0]][b*BYTE_W +: BYTE_W];
      end
    end else begin
      mem_d = mem_q;
    end
  end

  // Array storage with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = ridx_ok_s ? mem_q[ridx[MEM_AW-1:0]] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word array, with programmable wait states and pslverr.
// Optional macro APB4_PSTRB_EN adds the pstrb byte-strobe input.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int WAIT_W     = 4
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB4_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  input  logic [WAIT_W-1:0]       cfg_wait,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int ADDR_LSB = addr_lsb_f(DATA_WIDTH);
  localparam int STRB_W   = strb_width_f(DATA_WIDTH);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ADDR_LSB) - 1);
  localparam logic [IDX_W:0]        DEPTH_L    = (IDX_W + 1)'(DEPTH);

  apb_state_e            state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [STRB_W-1:0]     strb_q, strb_d;

  logic [IDX_W-1:0]      setup_idx_s;
  logic                  setup_err_s;
  logic [STRB_W-1:0]     strb_in_s;
  logic                  mem_we_s;
  logic                  pready_s;
  logic [DATA_WIDTH-1:0] mem_rdata_s;

`ifdef APB4_PSTRB_EN
  assign strb_in_s = pstrb;
`else
  assign strb_in_s = {STRB_W{1'b1}};
`endif

  // The mask form of the alignment check also covers byte-wide data (empty mask).
  assign setup_idx_s = paddr[ADDR_WIDTH-1:ADDR_LSB];
  assign setup_err_s = ((paddr & ALIGN_MASK) != '0) || ({1'b0, setup_idx_s} >= DEPTH_L);

  assign pready_s = (state_q == ACCESS) && (cnt_q == '0) && psel && penable;

  // Next-state logic: SETUP capture, wait countdown, completion and abort.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    strb_d   = strb_q;
    mem_we_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          idx_d   = setup_idx_s;
          write_d = pwrite;
          wdata_d = pwdata;
          err_d   = setup_err_s;
          strb_d  = strb_in_s;
          cnt_d   = cfg_wait;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else if (penable) begin
          mem_we_s = write_q && !err_q;
          state_d  = IDLE;
        end else begin
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transfer context registers.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      strb_q  <= strb_d;
    end
  end

  apb_slave_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_regfile (
    .clk  (pclk),
    .rst  (prst),
    .we   (mem_we_s),
    .widx (idx_q),
    .wdata(wdata_q),
    .wstrb(strb_q),
    .ridx (idx_q),
    .rdata(mem_rdata_s)
  );

  assign pready  = pready_s;
  assign pslverr = pready_s && err_q;
  assign prdata  = (pready_s && !write_q && !err_q) ? mem_rdata_s : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized self-checking bench for apb_slave_mem against a word-array reference model.
module tb_apb_slave_mem;

  localparam int DEPTH = 16;

  logic        pclk;
  logic        prst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
`ifdef APB4_PSTRB_EN
  logic [3:0]  pstrb_v;
`endif
  logic [3:0]  cfg_wait;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  logic [31:0] model_mem [DEPTH];
  int          n_checks;
  int          n_errors;

  apb_slave_mem #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .DEPTH     (DEPTH),
    .WAIT_W    (4)
  ) dut (
    .pclk    (pclk),
    .prst    (prst),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
`ifdef APB4_PSTRB_EN
    .pstrb   (pstrb_v),
`endif
    .cfg_wait(cfg_wait),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endtask

  // One APB transfer; abort_k >= 0 drops psel on that ACCESS cycle instead of completing.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [3:0] w, input int abort_k);
    int          idx;
    logic        err;
    logic [31:0] exp_rd;
    bit          aborted;
`ifndef APB4_PSTRB_EN
    strb = 4'hF;
`endif
    idx     = int'(addr) / 4;
    err     = (addr % 8'd4 != 8'd0) || (idx >= DEPTH);
    exp_rd  = (!wr && !err) ? model_mem[idx % DEPTH] : 32'h0;
    aborted = 1'b0;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; cfg_wait = w;
`ifdef APB4_PSTRB_EN
    pstrb_v = strb;
`endif
    #1 check_eq("setup_pready", {63'h0, pready}, 64'h0);
    for (int k = 0; k <= int'(w); k++) begin
      @(negedge pclk);
      penable  = 1'b1;
      cfg_wait = 4'($urandom);
      pwdata   = $urandom;
      paddr    = 8'($urandom);
      pwrite   = 1'($urandom);
      if (k == abort_k) begin
        psel = 1'b0; penable = 1'b0;
        #1 check_eq("abort_pready", {63'h0, pready}, 64'h0);
        aborted = 1'b1;
        break;
      end
      #1 check_eq($sformatf("pready_k%0d_w%0d", k, w), {63'h0, pready}, {63'h0, (k == int'(w))});
      if (k == int'(w)) begin
        check_eq($sformatf("prdata_a%0h", addr), {32'h0, prdata}, {32'h0, exp_rd});
        check_eq($sformatf("pslverr_a%0h", addr), {63'h0, pslverr}, {63'h0, err});
      end
    end
    if (!aborted && wr && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
      end
    end
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    #1 check_eq("idle_pready", {63'h0, pready}, 64'h0);
  endtask

  // Assert reset during the wait phase of a write: outputs must drop at once, array clears.
  task automatic reset_mid_access(input logic [7:0] addr);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = 32'hCAFEF00D; cfg_wait = 4'd5;
`ifdef APB4_PSTRB_EN
    pstrb_v = 4'hF;
`endif
    @(negedge pclk); penable = 1'b1;
    @(negedge pclk);
    prst = 1'b1;
    #1;
    check_eq("rst_pready", {63'h0, pready}, 64'h0);
    check_eq("rst_pslverr", {63'h0, pslverr}, 64'h0);
    check_eq("rst_prdata", {32'h0, prdata}, 64'h0);
    clear_model();
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; prst = 1'b0;
  endtask

  initial begin
    logic       wr;
    logic [7:0] addr;
    logic [3:0] w;
    int         ak;
    n_checks = 0; n_errors = 0;
    prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h0; pwdata = 32'h0; cfg_wait = 4'h0;
`ifdef APB4_PSTRB_EN
    pstrb_v = 4'h0;
`endif
    clear_model();
    repeat (2) @(negedge pclk);
    check_eq("reset_pready", {63'h0, pready}, 64'h0);
    check_eq("reset_pslverr", {63'h0, pslverr}, 64'h0);
    check_eq("reset_prdata", {32'h0, prdata}, 64'h0);
    prst = 1'b0;

    xfer(1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 4'd0, -1);
    xfer(1'b0, 8'h08, 32'h0, 4'hF, 4'd0, -1);
    xfer(1'b0, 8'h04, 32'h0, 4'hF, 4'd3, -1);
    xfer(1'b1, 8'h40, 32'h12345678, 4'hF, 4'd1, -1);
    xfer(1'b0, 8'h02, 32'h0, 4'hF, 4'd0, -1);
    xfer(1'b0, 8'h3C, 32'h0, 4'hF, 4'd0, -1);
    xfer(1'b1, 8'h10, 32'h55AA55AA, 4'hF, 4'd5, 2);
    xfer(1'b0, 8'h10, 32'h0, 4'hF, 4'd0, -1);
    xfer(1'b1, 8'h3C, 32'hA5A5F00F, 4'hF, 4'd15, -1);
    xfer(1'b0, 8'h3C, 32'h0, 4'hF, 4'd2, -1);

    // SETUP skipped (psel and penable together in IDLE) must not start a transfer.
    @(negedge pclk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h0BADC0DE;
    #1 check_eq("proto_pready0", {63'h0, pready}, 64'h0);
    @(negedge pclk);
    #1 check_eq("proto_pready1", {63'h0, pready}, 64'h0);
    psel = 1'b0; penable = 1'b0;
    xfer(1'b0, 8'h08, 32'h0, 4'hF, 4'd0, -1);

`ifdef APB4_PSTRB_EN
    xfer(1'b1, 8'h0C, 32'h11223344, 4'hF, 4'd0, -1);
    xfer(1'b1, 8'h0C, 32'hAABBCCDD, 4'b0101, 4'd1, -1);
    xfer(1'b0, 8'h0C, 32'h0, 4'hF, 4'd0, -1);
    check_eq("strb_model", {32'h0, model_mem[3]}, 64'h11BB33DD);
    xfer(1'b1, 8'h0C, 32'hFFFFFFFF, 4'b0000, 4'd0, -1);
    xfer(1'b0, 8'h0C, 32'h0, 4'hF, 4'd0, -1);
`endif

    for (int n = 0; n < 250; n++) begin
      wr = 1'($urandom);
      if ($urandom_range(0, 3) != 0) addr = 8'($urandom_range(0, DEPTH - 1) * 4);
      else addr = 8'($urandom);
      w  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      ak = -1;
      if (w != 4'd0 && $urandom_range(0, 9) == 0) ak = $urandom_range(0, int'(w) - 1);
      xfer(wr, addr, $urandom, 4'($urandom), w, ak);
    end

    reset_mid_access(8'h14);
    for (int i = 0; i < DEPTH; i++) xfer(1'b0, 8'(i * 4), 32'h0, 4'hF, 4'd0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
